// File: rtl/computation_mc_if.sv
// Bus bundle for computation_mc: operation request, operands and registered results.
// The master side issues requests and the slave side (the datapath) computes them.
interface computation_mc_if #(
  parameter int WIDTH = 16
);
  // Handshake: a request is taken on any rising edge where start=1, busy=0 and
  // reset=0. All other request fields are sampled on that same edge. done=1
  // for exactly one cycle after the edge that writes the result. A new request
  // may already be presented in the done cycle.
  logic             start;
  logic             asel;
  logic             bsel;
  logic             loadc;
  logic             loads;
  logic [1:0]       shift;
  logic [2:0]       ALUop;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic [WIDTH-1:0] sximm;
  logic [WIDTH-1:0] C;
  logic [2:0]       status;
  logic             busy;
  logic             done;
  logic             dbg_state;

  modport master (
    output start, asel, bsel, loadc, loads, shift, ALUop, A, B, sximm,
    input  C, status, busy, done, dbg_state
  );

  modport slave (
    input  start, asel, bsel, loadc, loads, shift, ALUop, A, B, sximm,
    output C, status, busy, done, dbg_state
  );
endinterface

// File: rtl/computation_mc.sv
// Shifter + ALU with registered result/flags; MUL runs as a WIDTH-step
// shift-add sequence, every other operation completes on the accepting edge.
module computation_mc #(
  parameter int WIDTH = 16
) (
  input  logic            clk,
  input  logic            reset,
  computation_mc_if.slave bus
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH - 1);

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_MVN = 3'b011;
  localparam logic [2:0] OP_MUL = 3'b100;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_MUL  = 1'b1
  } state_t;

  state_t state, state_nxt;

  logic [WIDTH-1:0] b_shift;
  logic [WIDTH-1:0] ain;
  logic [WIDTH-1:0] bin;
  logic [WIDTH-1:0] alu_res;
  logic             alu_v;

  logic [WIDTH-1:0] mul_a;
  logic [WIDTH-1:0] mul_b;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] step_sum;
  logic [CW-1:0]    cnt;
  logic             mul_loadc;
  logic             mul_loads;

  logic             accept;
  logic             accept_mul;
  logic             mul_last;

  logic             wr_en;
  logic             wr_c;
  logic             wr_s;
  logic [WIDTH-1:0] wr_res;
  logic             wr_v;

  logic [WIDTH-1:0] c_q;
  logic [2:0]       status_q;
  logic             done_q;

  // B shifter
  always_comb begin
    b_shift = bus.B;
    unique case (bus.shift)
      2'b00: b_shift = bus.B;
      2'b01: b_shift = {bus.B[WIDTH-2:0], 1'b0};
      2'b10: b_shift = {1'b0, bus.B[WIDTH-1:1]};
      2'b11: b_shift = {bus.B[WIDTH-1], bus.B[WIDTH-1:1]};
    endcase
  end

  assign ain = bus.asel ? '0 : bus.A;
  assign bin = bus.bsel ? bus.sximm : b_shift;

  // Single-cycle ALU; MUL and reserved codes produce 0 here (MUL result comes from acc)
  always_comb begin
    alu_res = '0;
    alu_v   = 1'b0;
    case (bus.ALUop)
      OP_ADD: begin
        alu_res = ain + bin;
        alu_v   = (ain[WIDTH-1] == bin[WIDTH-1]) && (alu_res[WIDTH-1] != ain[WIDTH-1]);
      end
      OP_SUB: begin
        alu_res = ain - bin;
        alu_v   = (ain[WIDTH-1] != bin[WIDTH-1]) && (alu_res[WIDTH-1] != ain[WIDTH-1]);
      end
      OP_AND:  alu_res = ain & bin;
      OP_MVN:  alu_res = ~bin;
      default: alu_res = '0;
    endcase
  end

  always_comb begin
    state_nxt  = state;
    accept     = 1'b0;
    accept_mul = 1'b0;
    mul_last   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (bus.start) begin
          accept = 1'b1;
          if (bus.ALUop == OP_MUL) begin
            accept_mul = 1'b1;
            state_nxt  = ST_MUL;
          end
        end
      end
      ST_MUL: begin
        if (cnt == LAST_STEP) begin
          mul_last  = 1'b1;
          state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  // One shift-add step: add the partial product selected by the current multiplier bit
  assign step_sum = acc + (mul_b[0] ? mul_a : '0);

  always_comb begin
    wr_en  = (accept && !accept_mul) || mul_last;
    wr_c   = (accept && !accept_mul && bus.loadc) || (mul_last && mul_loadc);
    wr_s   = (accept && !accept_mul && bus.loads) || (mul_last && mul_loads);
    wr_res = mul_last ? step_sum : alu_res;
    wr_v   = mul_last ? 1'b0 : alu_v;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      c_q       <= '0;
      status_q  <= 3'b000;
      done_q    <= 1'b0;
      cnt       <= '0;
      acc       <= '0;
      mul_a     <= '0;
      mul_b     <= '0;
      mul_loadc <= 1'b0;
      mul_loads <= 1'b0;
    end else begin
      done_q <= wr_en;
      if (wr_c) c_q <= wr_res;
      if (wr_s) status_q <= {wr_res[WIDTH-1], wr_v, (wr_res == '0)};

      if (accept_mul) begin
        mul_a     <= ain;
        mul_b     <= bin;
        acc       <= '0;
        cnt       <= '0;
        mul_loadc <= bus.loadc;
        mul_loads <= bus.loads;
      end else if (state == ST_MUL) begin
        acc   <= step_sum;
        mul_a <= mul_a << 1;
        mul_b <= mul_b >> 1;
        cnt   <= mul_last ? '0 : cnt + 1'b1;
      end
    end
  end

  assign bus.C         = c_q;
  assign bus.status    = status_q;
  assign bus.done      = done_q;
  assign bus.busy      = (state == ST_MUL);
  assign bus.dbg_state = (state == ST_MUL);

endmodule

// File: tb/tb_computation_mc.sv
// Self-checking bench for computation_mc (WIDTH=16): directed cases, MUL timing,
// reset abort, back-to-back requests and randomized ops against a reference model.
module tb_computation_mc;
  localparam int W = 16;
  localparam logic [2:0] ADD = 3'b000, SUB = 3'b001, AND_OP = 3'b010, MUL = 3'b100;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  computation_mc_if #(.WIDTH(W)) bus ();
  computation_mc #(.WIDTH(W)) dut (.clk(clk), .reset(reset), .bus(bus));

  int checks = 0;
  int failures = 0;
  logic [W+2:0] exp_q[$];
  logic [W-1:0] exp_c;
  logic [2:0]   exp_s;

  // ---------------- driver tasks ----------------
  task automatic drive_idle();
    bus.start = 1'b0; bus.asel = 1'b0; bus.bsel = 1'b0; bus.loadc = 1'b0; bus.loads = 1'b0;
    bus.shift = 2'b00; bus.ALUop = 3'b000; bus.A = '0; bus.B = '0; bus.sximm = '0;
  endtask

  task automatic drive_op(input logic s, input logic asl, input logic bsl, input logic lc,
                          input logic ls, input logic [1:0] sh, input logic [2:0] op,
                          input logic [W-1:0] a, input logic [W-1:0] b, input logic [W-1:0] sx);
    bus.start = s; bus.asel = asl; bus.bsel = bsl; bus.loadc = lc; bus.loads = ls;
    bus.shift = sh; bus.ALUop = op; bus.A = a; bus.B = b; bus.sximm = sx;
  endtask

  // ---------------- reference model ----------------
  // Returns {N,V,Z,result} computed from the operation rules with plain arithmetic.
  function automatic logic [W+2:0] model(input logic asl, input logic bsl, input logic [1:0] sh,
                                         input logic [2:0] op, input logic [W-1:0] a,
                                         input logic [W-1:0] b, input logic [W-1:0] sx);
    logic [W-1:0] bs, ai, bi, r;
    logic signed [W-1:0] sb, sai, sbi;
    int ia, ib, full;
    logic v;
    longint unsigned prod;
    sb = b;
    case (sh)
      2'b00:   bs = b;
      2'b01:   bs = b << 1;
      2'b10:   bs = b >> 1;
      default: bs = sb >>> 1;
    endcase
    ai = asl ? '0 : a;
    bi = bsl ? sx : bs;
    sai = ai; sbi = bi;
    ia = sai; ib = sbi;
    v = 1'b0;
    r = '0;
    full = 0;
    case (op)
      3'b000: begin full = ia + ib; r = full[W-1:0]; v = (full > 32767) || (full < -32768); end
      3'b001: begin full = ia - ib; r = full[W-1:0]; v = (full > 32767) || (full < -32768); end
      3'b010: r = ai & bi;
      3'b011: r = ~bi;
      3'b100: begin prod = longint'(ai) * longint'(bi); r = prod[W-1:0]; end
      default: r = '0;
    endcase
    return {r[W-1], v, (r == '0), r};
  endfunction

  // Drives a request and records the expected post-operation register contents.
  task automatic issue(input logic asl, input logic bsl, input logic lc, input logic ls,
                       input logic [1:0] sh, input logic [2:0] op,
                       input logic [W-1:0] a, input logic [W-1:0] b, input logic [W-1:0] sx);
    logic [W+2:0] m;
    m = model(asl, bsl, sh, op, a, b, sx);
    if (lc) exp_c = m[W-1:0];
    if (ls) exp_s = m[W+2:W];
    exp_q.push_back({exp_s, exp_c});
    drive_op(1'b1, asl, bsl, lc, ls, sh, op, a, b, sx);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset = 1'b1;
    drive_op(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 2'b00, ADD, 16'h0001, 16'h0001, '0);
    repeat (2) @(posedge clk);
    #1;
    checks++; if (bus.C !== 16'h0000) begin failures++; $display("FAIL reset_c got=%h exp=0000", bus.C); end
    checks++; if (bus.status !== 3'b000) begin failures++; $display("FAIL reset_status got=%b exp=000", bus.status); end
    checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", bus.busy); end
    checks++; if (bus.done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", bus.done); end
    checks++; if (bus.dbg_state !== 1'b0) begin failures++; $display("FAIL reset_state got=%b exp=0", bus.dbg_state); end
    reset = 1'b0;
    drive_idle();
    @(posedge clk); #1;
    checks++; if (bus.done !== 1'b0) begin failures++; $display("FAIL reset_idle_done got=%b exp=0", bus.done); end
    exp_c = '0; exp_s = 3'b000;
  endtask

  task automatic test_single_cycle();
    @(negedge clk);
    drive_op(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 2'b00, ADD, 16'h7FFF, 16'h0001, '0);
    @(posedge clk); #1; drive_idle();
    checks++; if (bus.C !== 16'h8000) begin failures++; $display("FAIL add_ovf_c got=%h exp=8000", bus.C); end
    checks++; if (bus.status !== 3'b110) begin failures++; $display("FAIL add_ovf_status got=%b exp=110", bus.status); end
    checks++; if (bus.done !== 1'b1) begin failures++; $display("FAIL add_done got=%b exp=1", bus.done); end
    @(posedge clk); #1;
    checks++; if (bus.done !== 1'b0) begin failures++; $display("FAIL add_done_once got=%b exp=0", bus.done); end

    @(negedge clk);
    drive_op(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 2'b00, SUB, 16'h0005, 16'h0005, '0);
    @(posedge clk); #1; drive_idle();
    checks++; if (bus.C !== 16'h0000) begin failures++; $display("FAIL sub_zero_c got=%h exp=0000", bus.C); end
    checks++; if (bus.status !== 3'b001) begin failures++; $display("FAIL sub_zero_status got=%b exp=001", bus.status); end

    @(negedge clk);
    drive_op(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 2'b11, ADD, 16'h1234, 16'h8004, '0);
    @(posedge clk); #1; drive_idle();
    checks++; if (bus.C !== 16'hC002) begin failures++; $display("FAIL asr_add_c got=%h exp=c002", bus.C); end
    checks++; if (bus.status !== 3'b100) begin failures++; $display("FAIL asr_add_status got=%b exp=100", bus.status); end

    @(negedge clk);
    drive_op(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, AND_OP, 16'h0000, 16'h0000, '0);
    @(posedge clk); #1; drive_idle();
    checks++; if (bus.C !== 16'hC002) begin failures++; $display("FAIL hold_c got=%h exp=c002", bus.C); end
    checks++; if (bus.status !== 3'b001) begin failures++; $display("FAIL hold_status got=%b exp=001", bus.status); end
    checks++; if (bus.done !== 1'b1) begin failures++; $display("FAIL hold_done got=%b exp=1", bus.done); end
    exp_c = 16'hC002; exp_s = 3'b001;
  endtask

  task automatic test_mul();
    int busy_cnt;
    int done_at;
    logic saw_state;
    @(negedge clk);
    drive_op(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 2'b00, MUL, 16'h0003, 16'h0005, '0);
    @(posedge clk); #1; drive_idle();
    busy_cnt = 0; done_at = -1; saw_state = 1'b0;
    for (int k = 0; k <= 24; k++) begin
      if (k > 0) begin @(posedge clk); #1; end
      if (bus.busy === 1'b1) busy_cnt++;
      if (k == 1) saw_state = bus.dbg_state;
      if (bus.done === 1'b1) begin done_at = k; break; end
      if (k == 5) drive_op(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 2'b00, ADD, 16'h0001, 16'h0001, '0);
      if (k == 6) drive_idle();
    end
    checks++; if (busy_cnt != W) begin failures++; $display("FAIL mul_busy_cycles got=%0d exp=%0d", busy_cnt, W); end
    checks++; if (done_at != W) begin failures++; $display("FAIL mul_done_edge got=%0d exp=%0d", done_at, W); end
    checks++; if (saw_state !== 1'b1) begin failures++; $display("FAIL mul_state got=%b exp=1", saw_state); end
    checks++; if (bus.C !== 16'h000F) begin failures++; $display("FAIL mul_c got=%h exp=000f", bus.C); end
    checks++; if (bus.status !== 3'b000) begin failures++; $display("FAIL mul_status got=%b exp=000", bus.status); end
    @(posedge clk); #1;
    checks++; if (bus.done !== 1'b0) begin failures++; $display("FAIL mul_done_once got=%b exp=0", bus.done); end
    checks++; if (bus.C !== 16'h000F) begin failures++; $display("FAIL mul_ignored_start got=%h exp=000f", bus.C); end

    @(negedge clk);
    drive_op(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 2'b00, MUL, 16'h0100, 16'h0100, '0);
    @(posedge clk); #1; drive_idle();
    done_at = -1;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk); #1;
      if (bus.done === 1'b1) begin done_at = k; break; end
    end
    checks++; if (done_at != W) begin failures++; $display("FAIL mul_wrap_done got=%0d exp=%0d", done_at, W); end
    checks++; if (bus.C !== 16'h0000) begin failures++; $display("FAIL mul_wrap_c got=%h exp=0000", bus.C); end
    checks++; if (bus.status !== 3'b001) begin failures++; $display("FAIL mul_wrap_status got=%b exp=001", bus.status); end
    exp_c = 16'h0000; exp_s = 3'b001;
  endtask

  task automatic test_reset_mid_mul();
    logic saw_done;
    @(negedge clk);
    drive_op(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 2'b00, ADD, 16'h1200, 16'h0034, '0);
    @(posedge clk); #1;
    drive_op(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 2'b00, MUL, 16'h0003, 16'h0005, '0);
    @(posedge clk); #1; drive_idle();
    checks++; if (bus.C !== 16'h1234) begin failures++; $display("FAIL pre_abort_c got=%h exp=1234", bus.C); end
    repeat (7) @(posedge clk);
    #1; reset = 1'b1;
    @(posedge clk); #1;
    checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL abort_busy got=%b exp=0", bus.busy); end
    checks++; if (bus.C !== 16'h0000) begin failures++; $display("FAIL abort_c got=%h exp=0000", bus.C); end
    checks++; if (bus.status !== 3'b000) begin failures++; $display("FAIL abort_status got=%b exp=000", bus.status); end
    reset = 1'b0;
    saw_done = 1'b0;
    for (int k = 0; k < 20; k++) begin
      if (bus.done === 1'b1) saw_done = 1'b1;
      @(posedge clk); #1;
    end
    checks++; if (saw_done !== 1'b0) begin failures++; $display("FAIL abort_no_done got=%b exp=0", saw_done); end
    @(negedge clk);
    drive_op(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 2'b00, ADD, 16'h0002, 16'h0003, '0);
    @(posedge clk); #1; drive_idle();
    checks++; if (bus.C !== 16'h0005 || bus.done !== 1'b1) begin
      failures++; $display("FAIL after_abort_add got=%h/%b exp=0005/1", bus.C, bus.done);
    end
    exp_c = 16'h0005; exp_s = 3'b000;
  endtask

  task automatic test_back_to_back();
    logic got;
    @(negedge clk);
    drive_op(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 2'b00, MUL, 16'h0007, 16'h0009, '0);
    @(posedge clk); #1; drive_idle();
    got = 1'b0;
    for (int k = 0; k < 40 && !got; k++) begin
      @(posedge clk); #1;
      if (bus.done === 1'b1) got = 1'b1;
    end
    checks++; if (got !== 1'b1 || bus.C !== 16'h003F) begin
      failures++; $display("FAIL b2b_mul got=%b/%h exp=1/003f", got, bus.C);
    end
    drive_op(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 2'b00, ADD, 16'd10, 16'd20, '0);
    @(posedge clk); #1;
    drive_op(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 2'b00, SUB, 16'd3, 16'd4, '0);
    checks++; if (bus.done !== 1'b1 || bus.C !== 16'h001E) begin
      failures++; $display("FAIL b2b_add got=%b/%h exp=1/001e", bus.done, bus.C);
    end
    @(posedge clk); #1; drive_idle();
    checks++; if (bus.done !== 1'b1 || bus.C !== 16'hFFFF || bus.status !== 3'b100) begin
      failures++; $display("FAIL b2b_sub got=%b/%h/%b exp=1/ffff/100", bus.done, bus.C, bus.status);
    end
    @(posedge clk); #1;
    checks++; if (bus.done !== 1'b0) begin failures++; $display("FAIL b2b_done_drop got=%b exp=0", bus.done); end
    exp_c = 16'hFFFF; exp_s = 3'b100;
  endtask

  task automatic test_random();
    logic [W+2:0] exp;
    logic [2:0] op;
    int n;
    int exp_lat;
    for (int i = 0; i < 40; i++) begin
      op = 3'($urandom_range(0, 7));
      @(negedge clk);
      issue(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), op,
            W'($urandom), W'($urandom), W'($urandom));
      @(posedge clk); #1; drive_idle();
      n = 0;
      while (bus.done !== 1'b1 && n < 2 * W + 4) begin
        @(posedge clk); #1; n++;
      end
      exp = exp_q.pop_front();
      exp_lat = (op == MUL) ? W : 0;
      checks++;
      if (bus.done !== 1'b1) begin
        failures++; $display("FAIL rand_timeout op=%0d waited=%0d", op, n);
      end else if (n != exp_lat || {bus.status, bus.C} !== exp) begin
        failures++;
        $display("FAIL rand_op%0d i=%0d got=%b/%h lat=%0d exp=%b/%h lat=%0d",
                 op, i, bus.status, bus.C, n, exp[W+2:W], exp[W-1:0], exp_lat);
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  initial begin
    drive_idle();
    test_reset();
    test_single_cycle();
    test_mul();
    test_reset_mid_mul();
    test_back_to_back();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
